// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory request channel, CPU redirect and instruction-buffer head.
// The master modport is the fetch unit; the slave modport is the memory/CPU environment.
interface fetch_unit_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_ready;
  logic        fault;

  modport master (
    output mem_req, mem_addr, ir_valid, ir, ir_pc, fault,
    input  mem_ack, mem_data, redirect, redirect_pc, ir_ready
  );

  modport slave (
    input  mem_req, mem_addr, ir_valid, ir, ir_pc, fault,
    output mem_ack, mem_data, redirect, redirect_pc, ir_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction prefetcher feeding a DEPTH-entry buffer, with redirect flush.
// Optional macro FETCH_FAULT_EN builds the sticky misaligned-redirect fault flag.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {FETCH = 1'b0, WAIT = 1'b1} state_t;

  state_t        stateR, stateNext;
  logic          reqR;
  logic          validR;
  logic [15:0]   pcR, pcNext;
  logic [AW-1:0] headR, headNext, tailR, tailNext;
  logic [CW-1:0] countR, countNext;
  logic [15:0]   wordBuf [DEPTH];
  logic [15:0]   addrBuf [DEPTH];
  logic          push, pop;

  // reqR is zero straight out of reset, so a stale ack during the first cycle never pushes
  assign push = reqR & bus.mem_ack & ~bus.redirect;
  assign pop  = validR & bus.ir_ready & ~bus.redirect;

  // Next-state, pointer, count and fetch-PC computation
  always_comb begin
    stateNext = stateR;
    pcNext    = pcR;
    headNext  = headR;
    tailNext  = tailR;
    countNext = countR;
    if (bus.redirect) begin
      stateNext = FETCH;
      pcNext    = {bus.redirect_pc[15:1], 1'b0};
      headNext  = '0;
      tailNext  = '0;
      countNext = '0;
    end else begin
      if (push) begin
        pcNext   = pcR + 16'd2;
        tailNext = tailR + AW'(1);
      end else begin
        pcNext   = pcR;
        tailNext = tailR;
      end
      if (pop) begin
        headNext = headR + AW'(1);
      end else begin
        headNext = headR;
      end
      countNext = countR + CW'(push) - CW'(pop);
      case (stateR)
        FETCH:   stateNext = (countNext == FULL) ? WAIT : FETCH;
        WAIT:    stateNext = (countNext < FULL) ? FETCH : WAIT;
        default: stateNext = FETCH;
      endcase
    end
  end

  // Control state, pointers and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR <= FETCH;
      reqR   <= 1'b0;
      validR <= 1'b0;
      pcR    <= RESET_PC;
      headR  <= '0;
      tailR  <= '0;
      countR <= '0;
    end else begin
      stateR <= stateNext;
      reqR   <= (stateNext == FETCH);
      validR <= (countNext != '0);
      pcR    <= pcNext;
      headR  <= headNext;
      tailR  <= tailNext;
      countR <= countNext;
    end
  end

  // Buffer storage carries no reset; validity is tracked by countR alone
  always_ff @(posedge clk) begin
    if (push) begin
      wordBuf[tailR] <= bus.mem_data;
      addrBuf[tailR] <= pcR;
    end
  end

  assign bus.mem_req  = reqR;
  assign bus.mem_addr = pcR;
  assign bus.ir_valid = validR;
  assign bus.ir       = wordBuf[headR];
  assign bus.ir_pc    = addrBuf[headR];

`ifdef FETCH_FAULT_EN
  logic faultR;

  // Sticky flag: any odd redirect target sets it until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      faultR <= 1'b0;
    end else if (bus.redirect && bus.redirect_pc[0]) begin
      faultR <= 1'b1;
    end else begin
      faultR <= faultR;
    end
  end

  assign bus.fault = faultR;
`else
  logic unusedPcBit;
  assign unusedPcBit = bus.redirect_pc[0];
  assign bus.fault   = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: main instance at RESET_PC 0000 plus a wrap-around instance at FFFC.
// Memory model returns mem_addr ^ 16'h5A00 as the instruction word.
module tb_fetch_unit;
  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic expFault;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  fetch_unit #(.DEPTH(4), .RESET_PC(16'hFFFC)) dutWrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.mem_data  = bus.mem_addr ^ 16'h5A00;
  always_comb bus2.mem_data = bus2.mem_addr ^ 16'h5A00;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
`ifdef FETCH_FAULT_EN
    expFault = 1'b1;
`else
    expFault = 1'b0;
`endif
    rst              = 1'b0;
    bus.mem_ack      = 1'b1;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 16'h0000;
    bus.ir_ready     = 1'b0;
    bus2.mem_ack     = 1'b1;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 16'h0000;
    bus2.ir_ready    = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", {15'd0, bus.mem_req}, 16'h0000);
    check("rst_ir_valid", {15'd0, bus.ir_valid}, 16'h0000);
    check("rst_fault", {15'd0, bus.fault}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Edge 1: request raised at RESET_PC
    tick();
    check("first_req", {15'd0, bus.mem_req}, 16'h0001);
    check("first_addr", bus.mem_addr, 16'h0000);
    check("first_ir_valid", {15'd0, bus.ir_valid}, 16'h0000);

    // Edge 2: word @0000 visible
    tick();
    check("fill1_valid", {15'd0, bus.ir_valid}, 16'h0001);
    check("fill1_ir", bus.ir, 16'h5A00);
    check("fill1_ir_pc", bus.ir_pc, 16'h0000);
    check("fill1_addr", bus.mem_addr, 16'h0002);
    check("wrap0_ir", bus2.ir, 16'hA5FC);
    check("wrap0_ir_pc", bus2.ir_pc, 16'hFFFC);
    tick();
    check("wrap1_ir_pc", bus2.ir_pc, 16'hFFFE);
    tick();
    check("wrap2_ir_pc", bus2.ir_pc, 16'h0000);
    check("wrap2_ir", bus2.ir, 16'h5A00);
    // Edge 5: fourth push fills the buffer
    tick();
    check("wrap3_ir_pc", bus2.ir_pc, 16'h0002);
    check("full_mem_req", {15'd0, bus.mem_req}, 16'h0000);
    check("full_ir_pc", bus.ir_pc, 16'h0000);
    check("full_ir", bus.ir, 16'h5A00);
    tick();
    check("full_hold_req", {15'd0, bus.mem_req}, 16'h0000);
    check("full_hold_addr", bus.mem_addr, 16'h0008);

    // One pop from full reopens fetching at 0008
    bus.ir_ready = 1'b1;
    tick();
    check("pop_req", {15'd0, bus.mem_req}, 16'h0001);
    check("pop_addr", bus.mem_addr, 16'h0008);
    check("pop_ir_pc", bus.ir_pc, 16'h0002);
    // Push and pop together keep count at 3
    tick();
    check("pp1_req", {15'd0, bus.mem_req}, 16'h0001);
    check("pp1_addr", bus.mem_addr, 16'h000A);
    check("pp1_ir_pc", bus.ir_pc, 16'h0004);
    tick();
    check("pp2_req", {15'd0, bus.mem_req}, 16'h0001);
    check("pp2_ir_pc", bus.ir_pc, 16'h0006);
    bus.ir_ready = 1'b0;
    tick();
    check("refill_req", {15'd0, bus.mem_req}, 16'h0000);
    check("refill_addr", bus.mem_addr, 16'h000E);

    // Pop once so a request is in flight, then redirect with ack and pop in the same cycle
    bus.ir_ready = 1'b1;
    tick();
    check("pre_redir_req", {15'd0, bus.mem_req}, 16'h0001);
    check("pre_redir_ir_pc", bus.ir_pc, 16'h0008);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0120;
    tick();
    bus.redirect = 1'b0;
    bus.ir_ready = 1'b0;
    check("redir_valid", {15'd0, bus.ir_valid}, 16'h0000);
    check("redir_req", {15'd0, bus.mem_req}, 16'h0001);
    check("redir_addr", bus.mem_addr, 16'h0120);
    tick();
    check("redir_ir_pc", bus.ir_pc, 16'h0120);
    check("redir_ir", bus.ir, 16'h5B20);
    check("redir_next_addr", bus.mem_addr, 16'h0122);

    // Misaligned redirect: fetch aligns to 0030, fault depends on FETCH_FAULT_EN
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0031;
    tick();
    bus.redirect = 1'b0;
    check("mis_addr", bus.mem_addr, 16'h0030);
    check("mis_fault", {15'd0, bus.fault}, {15'd0, expFault});
    check("mis_valid", {15'd0, bus.ir_valid}, 16'h0000);
    tick();
    check("mis_ir_pc", bus.ir_pc, 16'h0030);
    check("mis_fault_sticky", {15'd0, bus.fault}, {15'd0, expFault});

    // Without ack, address and request hold
    bus.mem_ack = 1'b0;
    tick();
    check("noack_req", {15'd0, bus.mem_req}, 16'h0001);
    check("noack_addr", bus.mem_addr, 16'h0032);
    check("noack_ir_pc", bus.ir_pc, 16'h0030);
    bus.mem_ack = 1'b1;
    tick();
    tick();
    check("three_addr", bus.mem_addr, 16'h0036);

    // Asynchronous reset with three entries buffered
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", {15'd0, bus.ir_valid}, 16'h0000);
    check("arst_req", {15'd0, bus.mem_req}, 16'h0000);
    check("arst_fault", {15'd0, bus.fault}, 16'h0000);
    check("arst_addr", bus.mem_addr, 16'h0000);
    tick();
    check("arst_hold_req", {15'd0, bus.mem_req}, 16'h0000);
    check("arst_hold_valid", {15'd0, bus.ir_valid}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("rel_req", {15'd0, bus.mem_req}, 16'h0001);
    check("rel_addr", bus.mem_addr, 16'h0000);
    check("rel_valid", {15'd0, bus.ir_valid}, 16'h0000);
    tick();
    check("rel_ir_valid", {15'd0, bus.ir_valid}, 16'h0001);
    check("rel_ir_pc", bus.ir_pc, 16'h0000);
    check("rel_ir", bus.ir, 16'h5A00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
